// File: rtl/oflow_mem_buffer_addr_gen.sv
// oflow_mem_buffer_addr_gen
//   Address generator for a circular history buffer of frames. A write sweeps
//   the current frame's bbox pairs into slot wr_slot. A read sweeps all stored
//   history frames, newest first. Every output is registered.
//
// Ports
//   i_clk, i_reset_N             clock; synchronous active-high reset
//   i_start_write, i_start_read  one-cycle requests, honoured only in IDLE
//   i_frame_num                  frame serial number (0 restarts the history)
//   i_num_of_history_frames      buffer depth D (0 behaves as 1)
//   i_num_of_bbox_in_frame       bbox count N of the frame
//   o_frame_to_read              slot addressed this cycle
//   o_offset_0 / o_offset_1      bbox pair offsets (offset_1 = offset_0 + 1)
//   o_valid_0 / o_valid_1        lane qualifiers
//   o_we                         buffer write enable (WRITE only)
//   o_done_write / o_done_read   one-cycle completion pulses
//   o_busy                       not IDLE
//   o_counter_of_history_frame   stored frame count, saturating at D
module oflow_mem_buffer_addr_gen #(
    parameter int TOTAL_FRAME_NUM_WIDTH       = 8,
    parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3,
    parameter int NUM_OF_BBOX_IN_FRAME_WIDTH  = 6
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset_N,
    input  logic                                   i_start_write,
    input  logic                                   i_start_read,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       i_frame_num,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] i_num_of_history_frames,
    input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  i_num_of_bbox_in_frame,
    output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] o_frame_to_read,
    output logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  o_offset_0,
    output logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  o_offset_1,
    output logic                                   o_valid_0,
    output logic                                   o_valid_1,
    output logic                                   o_we,
    output logic                                   o_done_write,
    output logic                                   o_done_read,
    output logic                                   o_busy,
    output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] o_counter_of_history_frame
);
    localparam int HW = NUM_OF_HISTORY_FRAMES_WIDTH;
    localparam int BW = NUM_OF_BBOX_IN_FRAME_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DONE_W, S_DONE_R} state_t;

    state_t          r_state, w_state;
    logic [HW-1:0]   r_wr_slot, w_wr_slot;
    logic [HW-1:0]   r_hist, w_hist;
    logic [HW-1:0]   r_depth, w_depth;
    logic [HW-1:0]   r_frames_left, w_frames_left;
    logic [BW-1:0]   r_n, w_n;
    logic [HW-1:0]   r_slot, w_slot;
    logic [BW-1:0]   r_off, w_off;
    logic [BW-1:0]   r_off1, w_off1;
    logic            r_v0, w_v0, r_v1, w_v1, r_we, w_we;
    logic            r_done_w, w_done_w, r_done_r, w_done_r, r_busy, w_busy;

    // Helpers. Offset arithmetic is one bit wider so off+2/off+3 cannot wrap.
    logic [HW-1:0]   w_in_depth, w_frames, w_rd_start, w_prev_slot, w_wr_inc, w_hist_inc;
    logic [BW:0]     w_off_step, w_n_ext;
    logic            w_pair_last;

    assign w_in_depth  = (i_num_of_history_frames == '0) ? HW'(1) : i_num_of_history_frames;
    // Never visit more frames than the buffer can hold.
    assign w_frames    = (r_hist < w_in_depth) ? r_hist : w_in_depth;
    assign w_rd_start  = (r_wr_slot == '0) ? w_in_depth - HW'(1) : r_wr_slot - HW'(1);
    assign w_prev_slot = (r_slot == '0) ? r_depth - HW'(1) : r_slot - HW'(1);
    assign w_wr_inc    = (r_wr_slot >= r_depth - HW'(1)) ? '0 : r_wr_slot + HW'(1);
    assign w_hist_inc  = (r_hist >= r_depth) ? r_depth : r_hist + HW'(1);
    assign w_n_ext     = {1'b0, r_n};
    assign w_off_step  = {1'b0, r_off} + (BW+1)'(2);
    assign w_pair_last = (w_off_step >= w_n_ext);

    always_comb begin
        w_state       = r_state;
        w_wr_slot     = r_wr_slot;
        w_hist        = r_hist;
        w_depth       = r_depth;
        w_frames_left = r_frames_left;
        w_n           = r_n;
        w_slot        = '0;
        w_off         = '0;
        w_v0          = 1'b0;
        w_v1          = 1'b0;
        w_we          = 1'b0;
        w_done_w      = 1'b0;
        w_done_r      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start_write) begin
                    w_state = S_WRITE;
                    w_n     = i_num_of_bbox_in_frame;
                    w_depth = w_in_depth;
                    if (i_frame_num == '0) begin
                        w_wr_slot = '0;
                        w_hist    = '0;
                    end
                    w_slot = w_wr_slot;
                    w_v0   = (i_num_of_bbox_in_frame != '0);
                    w_v1   = (i_num_of_bbox_in_frame > BW'(1));
                    w_we   = w_v0;
                end else if (i_start_read) begin
                    w_state       = S_READ;
                    w_n           = i_num_of_bbox_in_frame;
                    w_depth       = w_in_depth;
                    w_frames_left = w_frames;
                    w_slot        = w_rd_start;
                    w_v0          = (w_frames != '0) && (i_num_of_bbox_in_frame != '0);
                    w_v1          = (w_frames != '0) && (i_num_of_bbox_in_frame > BW'(1));
                end
            end
            S_WRITE: begin
                if (w_pair_last) begin
                    w_state   = S_DONE_W;
                    w_wr_slot = w_wr_inc;
                    w_hist    = w_hist_inc;
                    w_done_w  = 1'b1;
                end else begin
                    w_slot = r_slot;
                    w_off  = w_off_step[BW-1:0];
                    w_v0   = 1'b1;
                    w_v1   = (w_off_step + (BW+1)'(1)) < w_n_ext;
                    w_we   = 1'b1;
                end
            end
            S_READ: begin
                // An empty history still spends one cycle here before DONE_R.
                if ((r_frames_left == '0) || (w_pair_last && r_frames_left == HW'(1))) begin
                    w_state  = S_DONE_R;
                    w_done_r = 1'b1;
                end else if (w_pair_last) begin
                    w_frames_left = r_frames_left - HW'(1);
                    w_slot        = w_prev_slot;
                    w_v0          = (r_n != '0);
                    w_v1          = (r_n > BW'(1));
                end else begin
                    w_slot = r_slot;
                    w_off  = w_off_step[BW-1:0];
                    w_v0   = 1'b1;
                    w_v1   = (w_off_step + (BW+1)'(1)) < w_n_ext;
                end
            end
            S_DONE_W, S_DONE_R: w_state = S_IDLE;
            default:            w_state = S_IDLE;
        endcase
    end

    assign w_off1 = w_off + BW'(1);
    assign w_busy = (w_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset_N) begin
            r_state       <= S_IDLE;
            r_wr_slot     <= '0;
            r_hist        <= '0;
            r_depth       <= '0;
            r_frames_left <= '0;
            r_n           <= '0;
            r_slot        <= '0;
            r_off         <= '0;
            r_off1        <= '0;
            r_v0          <= 1'b0;
            r_v1          <= 1'b0;
            r_we          <= 1'b0;
            r_done_w      <= 1'b0;
            r_done_r      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_wr_slot     <= w_wr_slot;
            r_hist        <= w_hist;
            r_depth       <= w_depth;
            r_frames_left <= w_frames_left;
            r_n           <= w_n;
            r_slot        <= w_slot;
            r_off         <= w_off;
            r_off1        <= w_off1;
            r_v0          <= w_v0;
            r_v1          <= w_v1;
            r_we          <= w_we;
            r_done_w      <= w_done_w;
            r_done_r      <= w_done_r;
            r_busy        <= w_busy;
        end
    end

    assign o_frame_to_read            = r_slot;
    assign o_offset_0                 = r_off;
    assign o_offset_1                 = r_off1;
    assign o_valid_0                  = r_v0;
    assign o_valid_1                  = r_v1;
    assign o_we                       = r_we;
    assign o_done_write               = r_done_w;
    assign o_done_read                = r_done_r;
    assign o_busy                     = r_busy;
    assign o_counter_of_history_frame = r_hist;
endmodule
